// File: rtl/flag_gen_seq.sv
// -----------------------------------------------------------------------------
// flag_gen_seq
//   Chunk-serial subtractor with NZCV flag generation. An operand pair is
//   captured in IDLE and A - B is formed CHUNK bits per clock, least
//   significant chunk first, as A + ~B + 1 with a rippled carry register.
//   After the last chunk the difference and flags are held in DONE until the
//   consumer accepts them.
//
// Parameters
//   WIDTH     operand / difference width (integer multiple of CHUNK)
//   CHUNK     bits processed per clock (>= 1)
//
// Ports
//   clk       clock, rising-edge active
//   rst_n     asynchronous active-low reset
//   in_valid  operand pair offered
//   in_ready  block can accept operands (IDLE only)
//   op_a      minuend A
//   op_b      subtrahend B
//   out_valid diff and flags valid (DONE only)
//   out_ready consumer takes the result
//   diff      A - B modulo 2^WIDTH (registered)
//   FlagN     negative: diff[WIDTH-1]
//   FlagZ     zero: diff == 0
//   FlagC     carry out of the subtraction (1 = no borrow)
//   FlagV     signed overflow of A - B
// -----------------------------------------------------------------------------
module flag_gen_seq #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             FlagN,
   output logic             FlagZ,
   output logic             FlagC,
   output logic             FlagV
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NCHUNK - 1);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             n_q, n_d;
   logic             z_q, z_d;
   logic             c_q, c_d;
   logic             v_q, v_d;

   // Current chunk slice and its adder
   logic [31:0]      base;
   logic [CHUNK-1:0] a_chunk;
   logic [CHUNK-1:0] b_chunk;
   logic [CHUNK:0]   sum;

   always_comb begin
      base    = 32'(cnt_q) * 32'(CHUNK);
      a_chunk = a_q[base +: CHUNK];
      b_chunk = b_q[base +: CHUNK];
      sum     = {1'b0, a_chunk} + {1'b0, ~b_chunk} + {{CHUNK{1'b0}}, carry_q};
   end

   // -------------------------------------------------------------------------
   // State register and datapath registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         diff_q  <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b1;
         n_q     <= 1'b0;
         z_q     <= 1'b0;
         c_q     <= 1'b0;
         v_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         diff_q  <= diff_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         n_q     <= n_d;
         z_q     <= z_d;
         c_q     <= c_d;
         v_q     <= v_d;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state and datapath logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      diff_d  = diff_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      n_d     = n_q;
      z_d     = z_q;
      c_d     = c_q;
      v_d     = v_q;

      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = op_a;
               b_d     = op_b;
               cnt_d   = '0;
               carry_d = 1'b1;
               // The previous result is dropped on accept so a partial diff
               // never carries stale high chunks.
               diff_d  = '0;
               n_d     = 1'b0;
               z_d     = 1'b0;
               c_d     = 1'b0;
               v_d     = 1'b0;
               state_d = CALC;
            end
         end

         CALC: begin
            diff_d[base +: CHUNK] = sum[CHUNK-1:0];
            carry_d = sum[CHUNK];
            if (cnt_q == LAST_CHUNK) begin
               // Flags are taken from the completed diff_d so they land in
               // the same edge as the final chunk.
               n_d     = diff_d[WIDTH-1];
               z_d     = (diff_d == '0);
               c_d     = sum[CHUNK];
               v_d     = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                         (diff_d[WIDTH-1] != a_q[WIDTH-1]);
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign diff      = diff_q;
   assign FlagN     = n_q;
   assign FlagZ     = z_q;
   assign FlagC     = c_q;
   assign FlagV     = v_q;

endmodule

// File: tb/tb_flag_gen_seq.sv
// -----------------------------------------------------------------------------
// tb_flag_gen_seq
//   Self-checking bench for flag_gen_seq (default WIDTH=32, CHUNK=8).
// -----------------------------------------------------------------------------
module tb_flag_gen_seq;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] op_a = '0;
   logic [W-1:0] op_b = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] diff;
   logic         FlagN, FlagZ, FlagC, FlagV;

   flag_gen_seq #(.WIDTH(32), .CHUNK(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op_a      (op_a),
      .op_b      (op_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
      .FlagN     (FlagN),
      .FlagZ     (FlagZ),
      .FlagC     (FlagC),
      .FlagV     (FlagV)
   );

   always #5 clk = ~clk;

   // f = {N, Z, C, V}
   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] d;
      logic [3:0]  f;
   } vec_t;

   vec_t vecs[$];
   vec_t sb[$];

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t model(input logic [31:0] a, input logic [31:0] b);
      vec_t   r;
      longint s;
      r.a = a;
      r.b = b;
      r.d = a - b;
      s   = longint'($signed(a)) - longint'($signed(b));
      r.f[3] = r.d[31];
      r.f[2] = (r.d == 32'd0);
      r.f[1] = (a >= b);
      r.f[0] = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      return r;
   endfunction

   function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] d, input logic [3:0] f);
      vec_t r;
      r.a = a; r.b = b; r.d = d; r.f = f;
      return r;
   endfunction

   // Accept an operand pair and wait (bounded) for out_valid.
   task automatic start_op(input vec_t v);
      int lat;
      lat = -1;
      @(negedge clk);
      check("in_ready_idle", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b1;
      op_a     = v.a;
      op_b     = v.b;
      @(posedge clk);
      sb.push_back(v);
      #1;
      in_valid = 1'b0;
      op_a     = $urandom;
      op_b     = $urandom;
      check("in_ready_calc", {31'd0, in_ready}, 32'd0);
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk);
         #1;
         if (out_valid) begin
            lat = k;
            break;
         end
      end
      check("latency", lat, 32'd4);
   endtask

   // Compare the result, hold it for 'hold' cycles under input noise, then
   // hand it off with in_valid high (which must not be accepted).
   task automatic finish_op(input int hold);
      vec_t e;
      @(negedge clk);
      if (sb.size() == 0) begin
         check("scoreboard_empty", 32'd0, 32'd1);
         return;
      end
      e = sb.pop_front();
      check("diff", diff, e.d);
      check("flags", {28'd0, FlagN, FlagZ, FlagC, FlagV}, {28'd0, e.f});
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         in_valid = ~in_valid;
         op_a     = $urandom;
         op_b     = $urandom;
         @(posedge clk);
         #1;
         check("hold_diff", diff, e.d);
         check("hold_flags", {28'd0, FlagN, FlagZ, FlagC, FlagV}, {28'd0, e.f});
         check("hold_rdy_vld", {30'd0, in_ready, out_valid}, 32'd1);
      end
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      op_a      = $urandom;
      op_b      = $urandom;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      in_valid  = 1'b0;
      check("handoff_idle", {30'd0, in_ready, out_valid}, 32'd2);
   endtask

   task automatic do_op(input vec_t v);
      start_op(v);
      finish_op(0);
   endtask

   initial begin
      // Directed vectors with hand-derived results
      vecs.push_back(mk(32'd5,          32'd5,          32'h0000_0000, 4'b0110));
      vecs.push_back(mk(32'd3,          32'd7,          32'hFFFF_FFFC, 4'b1000));
      vecs.push_back(mk(32'h8000_0000,  32'd1,          32'h7FFF_FFFF, 4'b0011));
      vecs.push_back(mk(32'h7FFF_FFFF,  32'hFFFF_FFFF,  32'h8000_0000, 4'b1001));
      vecs.push_back(mk(32'h0000_0100,  32'h0000_0001,  32'h0000_00FF, 4'b0010));
      vecs.push_back(mk(32'h0000_0000,  32'hFFFF_FFFF,  32'h0000_0001, 4'b0000));
      vecs.push_back(mk(32'h0000_0000,  32'h0000_0000,  32'h0000_0000, 4'b0110));
      vecs.push_back(mk(32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0000, 4'b0110));
      vecs.push_back(mk(32'h0001_0000,  32'h0000_0001,  32'h0000_FFFF, 4'b0010));
      // Model-derived vectors
      for (int i = 0; i < 6; i++) begin
         vecs.push_back(model($urandom, $urandom));
      end

      // Reset state, before and across a clock edge
      #3;
      check("rst_diff", diff, 32'd0);
      check("rst_flags", {28'd0, FlagN, FlagZ, FlagC, FlagV}, 32'd0);
      check("rst_rdy_vld", {30'd0, in_ready, out_valid}, 32'd2);
      in_valid = 1'b1;
      op_a     = 32'd9;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("rst_hold_rdy_vld", {30'd0, in_ready, out_valid}, 32'd2);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         do_op(vecs[i]);
      end

      // Backpressure: 3 stalled cycles in DONE
      start_op(model(32'h1234_5678, 32'h0F0F_0F0F));
      finish_op(3);

      // Back-to-back without idle gap beyond the mandatory one
      do_op(model(32'hDEAD_BEEF, 32'hBEEF_DEAD));

      // Reset mid-CALC after chunk 2 has been written
      @(negedge clk);
      in_valid = 1'b1;
      op_a     = 32'hFFFF_FFFF;
      op_b     = 32'h0000_0000;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("midcalc_rst_diff", diff, 32'd0);
      check("midcalc_rst_flags", {28'd0, FlagN, FlagZ, FlagC, FlagV}, 32'd0);
      check("midcalc_rst_rdy_vld", {30'd0, in_ready, out_valid}, 32'd2);
      @(negedge clk);
      rst_n = 1'b1;
      do_op(mk(32'd10, 32'd4, 32'd6, 4'b0010));

      // Reset while holding a result in DONE
      start_op(mk(32'd1, 32'd2, 32'hFFFF_FFFF, 4'b1000));
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("done_rst_diff", diff, 32'd0);
      check("done_rst_rdy_vld", {30'd0, in_ready, out_valid}, 32'd2);
      void'(sb.pop_front());
      @(negedge clk);
      rst_n = 1'b1;
      do_op(model(32'h0000_0001, 32'h8000_0000));

      check("scoreboard_drained", sb.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/flag_gen_seq.md
FLAG_GEN_SEQ -- requirements
Module: flag_gen_seq

Interface
REQ-001 Parameter: WIDTH, 32, operand and difference width in bits.
REQ-002 Parameter: CHUNK, 8, bits subtracted per clock; WIDTH SHALL be an integer multiple of CHUNK, and CHUNK SHALL be at least 1.
REQ-003 Port: clk  input  1  single clock, all state updates on rising edge.
REQ-004 Port: rst_n  input  1  asynchronous active-low reset.
REQ-005 Port: in_valid  input  1  operand pair offered.
REQ-006 Port: in_ready  output  1  block can accept operands.
REQ-007 Port: op_a  input  WIDTH  minuend A.
REQ-008 Port: op_b  input  WIDTH  subtrahend B.
REQ-009 Port: out_valid  output  1  result and flags valid.
REQ-010 Port: out_ready  input  1  consumer takes result.
REQ-011 Port: diff  output  WIDTH  A - B modulo 2^WIDTH.
REQ-012 Port: FlagN, FlagZ, FlagC, FlagV  output  1 each  negative, zero, carry (1 = no borrow), signed overflow of A - B.

Function
REQ-013 FSM states SHALL be IDLE, CALC and DONE, with exactly one state active.
REQ-014 in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-015 In IDLE, in_valid=1 at a rising edge SHALL capture op_a and op_b into internal registers, clear the chunk counter, set the carry register to 1 and enter CALC; op_a and op_b SHALL be ignored at all other times.
REQ-016 Each CALC cycle SHALL compute chunk i = A[i] + ~B[i] + carry, write the sum into diff bits [i*CHUNK +: CHUNK], store the carry-out and increment i.
REQ-017 After chunk WIDTH/CHUNK-1 is processed, the FSM SHALL enter DONE; out_valid SHALL rise exactly WIDTH/CHUNK rising edges after the accepting edge (4 for defaults).
REQ-018 FlagC SHALL equal the final carry-out.
REQ-019 FlagN SHALL equal diff[WIDTH-1].
REQ-020 FlagZ SHALL be 1 iff diff is all zeros.
REQ-021 FlagV SHALL equal (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]).
REQ-022 In DONE, diff and all flags SHALL hold stable until out_ready=1 at a rising edge, after which the FSM SHALL return to IDLE.
REQ-023 A new operand pair SHALL NOT be accepted in the same cycle as the result handoff; the earliest next accept is the cycle after the return to IDLE.
REQ-024 in_valid in CALC or DONE SHALL have no effect, and out_ready outside DONE SHALL have no effect.
REQ-025 diff and the flags SHALL be registered outputs with no combinational path from any input.

Reset
REQ-026 rst_n=0 SHALL immediately, without waiting for a clock edge, force IDLE, in_ready=1, out_valid=0, and diff, FlagN, FlagZ, FlagC, FlagV and the chunk counter to 0.
REQ-027 Reset asserted during CALC or DONE SHALL abort the operation with no residual result, and the first operation after reset release SHALL behave exactly as from power-up.
REQ-028 After rst_n deasserts, the first rising edge with in_valid=1 SHALL be accepted.

Verification
REQ-029 Equal operands: A=5, B=5 -> diff=0, Z=1, C=1, N=0, V=0, with out_valid exactly 4 cycles after accept.
REQ-030 Unsigned/signed less-than: A=3, B=7 -> diff=0xFFFFFFFC, N=1, C=0, V=0, Z=0.
REQ-031 Signed overflow: A=0x80000000, B=1 -> diff=0x7FFFFFFF, N=0, V=1, C=1, Z=0; and A=0x7FFFFFFF, B=0xFFFFFFFF -> diff=0x80000000, N=1, V=1, C=0.
REQ-032 Cross-chunk borrow: A=0x00000100, B=0x00000001 -> diff=0x000000FF, C=1, N=0, Z=0; and A=0, B=0xFFFFFFFF -> diff=1, C=0, V=0.
REQ-033 Backpressure: hold out_ready=0 for 3 cycles in DONE while toggling in_valid, op_a and op_b -> diff and flags unchanged and in_ready=0; then assert out_ready -> IDLE on the next edge.
REQ-034 Reset mid-CALC: pulse rst_n low after chunk 2 -> outputs are 0 immediately; after release, A=10, B=4 -> diff=6, C=1, N=0, Z=0, V=0.
